// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: drains the async FIFO read port into a 2-entry skid-buffered valid/ready stream; define FIFO_RD_PKT_LAST_EN for out_last packet framing
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 8
) (
    input  logic                  rd_clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;

    state_e                state_q, state_d;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  take, to_head, to_tail;
    logic [2:0]            occ_nxt;

    assign out_valid = state_q != EMPTY;
    assign out_data  = head_q;

    // next occupancy, pop credit and skid-buffer shift; a captured word lands at slot occ_nxt-1
    always_comb begin
        take       = out_valid & out_ready;
        occ_nxt    = {1'b0, state_q} + {2'b0, pend_q} - {2'b0, take};
        state_d    = occ_nxt == 3'd0 ? EMPTY : occ_nxt == 3'd1 ? ONE : FULL;
        fifo_rd_en = ~rst & ~fifo_empty & (occ_nxt < 3'd2);
        to_head    = pend_q & (occ_nxt == 3'd1);
        to_tail    = pend_q & (occ_nxt == 3'd2);
        head_d     = to_head ? fifo_rdata : take ? tail_q : head_q;
        tail_d     = to_tail ? fifo_rdata : tail_q;
    end

    // buffer state, in-flight pop flag and the two data entries
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            pend_q  <= 1'b0;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= fifo_rd_en;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

`ifdef FIFO_RD_PKT_LAST_EN
    localparam int CW = PKT_LEN > 1 ? $clog2(PKT_LEN) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          hlast_q, hlast_d, tlast_q, tlast_d, cap_last;

    // packet position counter advances per capture; last bits follow their words through the buffer
    always_comb begin
        cap_last = cnt_q == CW'(PKT_LEN - 1);
        cnt_d    = ~pend_q ? cnt_q : cap_last ? '0 : cnt_q + CW'(1);
        hlast_d  = to_head ? cap_last : take ? tlast_q : hlast_q;
        tlast_d  = to_tail ? cap_last : tlast_q;
    end

    // framing registers
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            hlast_q <= 1'b0;
            tlast_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            hlast_q <= hlast_d;
            tlast_q <= tlast_d;
        end
    end

    assign out_last = hlast_q;
`else
    assign out_last = 1'b0;
`endif
endmodule
